// File: rtl/factorial_engine_if.sv
// Host-side bundle for factorial_engine: request (start/operand/mode/abort) and result/status.
// Handshake: start_i is a one-shot valid; the engine is ready whenever busy_o is low or done_o is high.
// A request presented without ready is dropped, not held, and abort_i in the same cycle vetoes it.
interface factorial_engine_if #(
  parameter int N_W   = 8,
  parameter int RES_W = 32
);
  logic             start_i;
  logic [N_W-1:0]   n_i;
  logic             mode_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic [RES_W-1:0] result_o;
  logic             ovf_o;

  modport master (
    output start_i, n_i, mode_i, abort_i,
    input  busy_o, done_o, result_o, ovf_o
  );

  modport slave (
    input  start_i, n_i, mode_i, abort_i,
    output busy_o, done_o, result_o, ovf_o
  );
endinterface

// File: rtl/factorial_engine.sv
// Iterative n! / n!! engine: one multiply per cycle, sticky overflow detection, abortable.
// Results are published in a single DONE cycle; done_o, result_o and ovf_o are registered together.
module factorial_engine #(
  parameter int N_W   = 8,
  parameter int RES_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  factorial_engine_if.slave     bus,
  output logic [1:0]            state_dbg
);

  localparam int P_W = RES_W + N_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] result_q;
  logic [N_W-1:0]   cnt;
  logic [N_W-1:0]   cnt_dec;
  logic [N_W-1:0]   step;
  logic [P_W-1:0]   prod;
  logic             mode_q;
  logic             ovf_flag;
  logic             ovf_q;
  logic             done_q;
  logic             cnt_ge2;
  logic             accept;
  logic             do_mul;
  logic             publish;

  assign step    = mode_q ? N_W'(2) : N_W'(1);
  assign cnt_ge2 = (cnt >= N_W'(2));
  // Saturating decrement: the counter must never wrap back into the multiply range.
  assign cnt_dec = (cnt >= step) ? (cnt - step) : '0;
  assign prod    = {{N_W{1'b0}}, acc} * {{RES_W{1'b0}}, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    do_mul  = 1'b0;
    publish = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          accept  = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort_i) begin
          state_n = S_IDLE;
        end else if (cnt_ge2) begin
          do_mul = 1'b1;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        // Abort beats publication: the previous result stays visible.
        publish = !bus.abort_i;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= {{(RES_W-1){1'b0}}, 1'b1};
      cnt      <= '0;
      mode_q   <= 1'b0;
      ovf_flag <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= publish;
      if (accept) begin
        cnt      <= bus.n_i;
        mode_q   <= bus.mode_i;
        acc      <= {{(RES_W-1){1'b0}}, 1'b1};
        ovf_flag <= 1'b0;
      end else if (do_mul) begin
        acc <= prod[RES_W-1:0];
        cnt <= cnt_dec;
        if (|prod[P_W-1:RES_W]) begin
          ovf_flag <= 1'b1;
        end
      end
      if (publish) begin
        result_q <= acc;
        ovf_q    <= ovf_flag;
      end
    end
  end

  // busy_o stays up through the done_o cycle so it falls one cycle after the pulse.
  assign bus.busy_o   = (state != S_IDLE) || done_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.ovf_o    = ovf_q;
  assign state_dbg    = state;

endmodule
